video_input_arbiter: RTL

- Round-robin arbiter that lets NUM_REQ pixel-word producers share one video_input_*_in write port of soc_system (writedata/write/waitrequest, Avalon-MM write-only).
- Sits in the FPGA fabric between the capture/preprocessing producers and a single soc_system video_input channel.
- Grants are held for a burst of up to MAX_BURST words, so packets from different sources do not interleave word-by-word.

---
 rtl/video_input_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/video_input_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ Avalon-MM write-only producers onto one video_input port.
// Define VIDEO_ARB_STATS_EN to add saturating word/grant statistics counters with a synchronous clear.
module video_input_arbiter #(
  parameter int NUM_REQ   = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ-1:0]        req_write,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         out_writedata,
  output logic                      out_write,
  input  logic                      out_waitrequest,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef VIDEO_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [31:0]               stat_words,
  output logic [31:0]               stat_grants
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*NUM_REQ-1:0] rot;
  logic [PTR_W:0]       pick_sum;
  logic [PTR_W-1:0]     pick;
  logic                 pick_vld;
  logic                 xfer;

  // Rotate requests so bit 0 is rr_ptr; scanning downward leaves the lowest rotated hit.
  always_comb begin
    rot      = {req_write, req_write} >> rr_ptr_q;
    pick_sum = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
        pick_vld = 1'b1;
      end
    end
    pick = (pick_sum >= (PTR_W + 1)'(NUM_REQ)) ? PTR_W'(pick_sum - (PTR_W + 1)'(NUM_REQ))
                                                : PTR_W'(pick_sum);
  end

  always_comb begin
    out_write       = 1'b0;
    out_writedata   = '0;
    req_waitrequest = '1;
    if (state_q == GRANT) begin
      out_write                = req_write[owner_q];
      out_writedata            = req_writedata[owner_q*DATA_W +: DATA_W];
      req_waitrequest[owner_q] = out_waitrequest;
    end
  end

  assign xfer  = out_write & ~out_waitrequest;
  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick;
          grant_d = NUM_REQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req_write[owner_q] || (xfer && cnt_q == CNT_W'(MAX_BURST - 1))) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef VIDEO_ARB_STATS_EN
  logic [31:0] words_q, grants_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      words_q  <= '0;
      grants_q <= '0;
    end else if (stat_clr) begin
      words_q  <= '0;
      grants_q <= '0;
    end else begin
      if (xfer && words_q != '1) words_q <= words_q + 1'b1;
      if (state_q == IDLE && pick_vld && grants_q != '1) grants_q <= grants_q + 1'b1;
    end
  end

  assign stat_words  = words_q;
  assign stat_grants = grants_q;
`endif

endmodule
